load_data_stage: RTL and testbench
==================================

// Module: load_data_stage
// PURPOSE
// - Receiving end of the load-address -> load-data hand-off in the LSQ load pipe.
// - Accepts one computed-address load packet (LOAD_DATA_PACKET) at a time.
// - Resolves the load by store-queue forwarding and/or a D-cache read, then aligns and extends the data.
// - Presents the result for CDB completion.
// - Drives load_data_free back to the address stage; upstream advances only when it is high.
// PARAMETERS
// - DATA_W      32  load/store data width, bits
// - BM_W        8   branch-mask width (B_MASK)
// - PRF_IDX_W   6   physical register index width
// - SQ_IDX_W    3   store-queue index width (sq_tail)
// PORTS
// - clock              in   1          rising-edge clock
// - reset              in   1          synchronous, active-low
// - load_data_packet   in   pkt        LOAD_DATA_PACKET{valid,dest_reg_idx,bm,load_addr,byte_mask,sq_tail,load_func}
// - load_data_free     out  1          stage can accept load_data_packet this cycle
// - sq_query_addr      out  DATA_W     word-aligned address for store-queue lookup
// - sq_query_mask      out  4          byte_mask of the held load
// - sq_query_tail      out  SQ_IDX_W   only stores older than this index are searched
// - sq_fwd_mask        in   4          bytes supplied by older stores
// - sq_fwd_data        in   DATA_W     forwarded bytes (lanes per sq_fwd_mask)
// - sq_stall           in   1          an older store has an unresolved address
// - dc_req_valid       out  1          D-cache read request
// - dc_req_addr        out  DATA_W     word-aligned request address
// - dc_req_accept      in   1          cache took the request
// - dc_resp_valid      in   1          read data returned (one response per accepted request)
// - dc_resp_data       in   DATA_W     returned word
// - cmpl_valid         out  1          completed load ready for CDB
// - cmpl_dest_reg_idx  out  PRF_IDX_W  destination physical register
// - cmpl_data          out  DATA_W     aligned, extended result
// - cmpl_bm            out  BM_W       current branch mask of result
// - cmpl_accept        in   1          CDB grant
// - b_mm_resolve       in   BM_W       one-hot resolving branch
// - b_mm_mispred       in   1          resolving branch mispredicted
// BEHAVIOUR
// - States: IDLE, QUERY, REQ, WAIT, DRAIN, DONE.
// - Reset (reset==0 at posedge) -> IDLE; held packet invalid; fwd regs 0.
// - Reset values of outputs: all valid outputs and data/idx/bm outputs 0; load_data_free=1.
// - load_data_free = (state==IDLE) | (state==DONE & cmpl_accept).
//   - When free and load_data_packet.valid: capture at posedge -> QUERY.
// - QUERY: drive the sq_query_* ports.
//   - sq_stall=1: stay.
//   - Otherwise latch sq_fwd_mask and sq_fwd_data.
//     - (fwd_mask & byte_mask)==byte_mask -> DONE (no cache access).
//     - Else -> REQ.
// - REQ: dc_req_valid=1, dc_req_addr={load_addr[31:2],2'b00}.
//   - dc_req_accept -> WAIT.
// - WAIT: on dc_resp_valid, build the word lane by lane: forwarded lane if fwd_mask bit set, else cache lane.
//   - Latch the word -> DONE.
// - DONE: cmpl_valid=1.
//   - cmpl_accept -> IDLE, or capture the next packet in the same cycle.
// - Alignment: shift word right by 8*load_addr[1:0].
//   - load_func[1:0]: 00 byte, 01 half, 10 word.
//   - load_func[2]=1: zero-extend; 0: sign-extend.
// - Min latency capture->cmpl_valid:
//   - 1 cycle with full forward.
//   - 3 cycles with cache (accept and response both immediate).
// - Branch resolve, any state, when (b_mm_resolve & bm)!=0:
//   - Not mispredicted: clear that bit in the held bm; cmpl_bm reflects it the same cycle.
//   - Mispredicted: squash.
//     - In QUERY, REQ or DONE -> IDLE; dc_req_valid and cmpl_valid are forced 0 that cycle.
//     - In WAIT -> DRAIN.
//     - DRAIN waits for dc_resp_valid, discards the data -> IDLE; load_data_free=0 while in DRAIN.
// - Resolve hitting the incoming packet on its capture cycle: clear or squash before it is stored.
//   - A squashed incoming packet is not captured.
// - dc_req_accept arriving on a squash cycle in REQ: request counts as issued -> DRAIN.
// - reset low mid-operation overrides everything; any in-flight cache response afterwards is ignored.
// - byte_mask beyond word boundary (misaligned) is unsupported; result undefined.
// STRUCTURE
// - Shared package (sys_defs): LOAD_DATA_PACKET, B_MASK, BYTE_MASK, MEM_SIZE enum, NOP_LOAD_DATA_PACKET, LD_STATE enum.
// - Sub-module load_align_ext: combinational shift + sign/zero-extend.
// TESTING
// 1. LW addr 0x1000, fwd_mask 0, resp 0xDEADBEEF, accept immediate -> cmpl_data 0xDEADBEEF 3 cycles after capture.
// 2. LB addr 0x1003, resp 0x80000000 -> 0xFFFFFF80; LBU (func 3'b100) same stimulus -> 0x00000080.
// 3. LH addr 0x2002 byte_mask 4'b1100, sq_fwd_mask 4'b1100, fwd_data 0x12340000 -> 0x00001234, dc_req_valid never 1.
// 4. LW, sq_fwd_mask 4'b0011 fwd 0x0000AAAA, resp 0x11223344 -> 0x1122AAAA.
// 5. Load bm 8'h04 in WAIT, resolve 8'h04 mispred -> DRAIN, response dropped, cmpl_valid stays 0, free after response.
// 6. Load bm 8'h06 in DONE, cmpl_accept held 0, resolve 8'h02 no mispred -> cmpl_bm 8'h04; reset low mid-REQ -> IDLE next cycle.

Source files
------------

// File: rtl/sys_defs.sv
// Shared load-pipe types: packet layout, masks, access sizes and load-data FSM states.
// Latency: none (types only). Backpressure: n/a.
package sys_defs;

  localparam int DATA_W    = 32;
  localparam int BM_W      = 8;
  localparam int PRF_IDX_W = 6;
  localparam int SQ_IDX_W  = 3;

  typedef logic [BM_W-1:0] B_MASK;
  typedef logic [3:0]      BYTE_MASK;

  typedef enum logic [1:0] {
    BYTE = 2'h0,
    HALF = 2'h1,
    WORD = 2'h2
  } MEM_SIZE;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_QUERY,
    LD_REQ,
    LD_WAIT,
    LD_DRAIN,
    LD_DONE
  } LD_STATE;

  // load_func[2] selects zero-extension, load_func[1:0] is a MEM_SIZE
  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] dest_reg_idx;
    B_MASK                bm;
    logic [DATA_W-1:0]    load_addr;
    BYTE_MASK             byte_mask;
    logic [SQ_IDX_W-1:0]  sq_tail;
    logic [2:0]           load_func;
  } LOAD_DATA_PACKET;

  localparam LOAD_DATA_PACKET NOP_LOAD_DATA_PACKET = '0;

  // Per-byte select: lanes with sel set come from a, the rest from b
  function automatic logic [DATA_W-1:0] lane_merge(input BYTE_MASK          sel,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? a[8*i +: 8] : b[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Right-aligns the addressed byte/half/word of a load and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
module load_align_ext import sys_defs::*; (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        load_func,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;
  logic              zext;

  assign shifted = word >> {byte_off, 3'b000};
  assign zext    = load_func[2];

  always_comb begin
    result = shifted;
    case (MEM_SIZE'(load_func[1:0]))
      BYTE:    result = {{(DATA_W-8){~zext & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{(DATA_W-16){~zext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_data_stage.sv
// Load-data stage: resolves one load by store-queue forwarding and/or a D-cache read, then aligns it for the CDB.
// Latency: capture->cmpl_valid 1 cycle on full forward, 3 cycles with immediate cache accept and response.
// Backpressure: load_data_free low while a load is held; the result is held until cmpl_accept.
module load_data_stage import sys_defs::*; (
  input  logic                 clock,
  input  logic                 reset,
  input  LOAD_DATA_PACKET      load_data_packet,
  output logic                 load_data_free,
  output logic [DATA_W-1:0]    sq_query_addr,
  output logic [3:0]           sq_query_mask,
  output logic [SQ_IDX_W-1:0]  sq_query_tail,
  input  logic [3:0]           sq_fwd_mask,
  input  logic [DATA_W-1:0]    sq_fwd_data,
  input  logic                 sq_stall,
  output logic                 dc_req_valid,
  output logic [DATA_W-1:0]    dc_req_addr,
  input  logic                 dc_req_accept,
  input  logic                 dc_resp_valid,
  input  logic [DATA_W-1:0]    dc_resp_data,
  output logic                 cmpl_valid,
  output logic [PRF_IDX_W-1:0] cmpl_dest_reg_idx,
  output logic [DATA_W-1:0]    cmpl_data,
  output logic [BM_W-1:0]      cmpl_bm,
  input  logic                 cmpl_accept,
  input  logic [BM_W-1:0]      b_mm_resolve,
  input  logic                 b_mm_mispred
);

  LD_STATE           state, next_state;
  LOAD_DATA_PACKET   pkt;
  BYTE_MASK          fwd_mask;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] word;

  logic squash;
  logic in_squash;
  logic capture;
  logic fwd_full;
  logic [DATA_W-1:0] word_addr;

  assign squash    = pkt.valid & b_mm_mispred & (|(b_mm_resolve & pkt.bm));
  assign in_squash = load_data_packet.valid & b_mm_mispred
                   & (|(b_mm_resolve & load_data_packet.bm));
  assign capture   = load_data_free & load_data_packet.valid & ~in_squash;
  assign fwd_full  = ((sq_fwd_mask & pkt.byte_mask) == pkt.byte_mask);
  assign word_addr = {pkt.load_addr[DATA_W-1:2], 2'b00};

  always_ff @(posedge clock) begin
    if (!reset) state <= LD_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE: begin
        if (capture) next_state = LD_QUERY;
      end
      LD_QUERY: begin
        if (squash)         next_state = LD_IDLE;
        else if (!sq_stall) next_state = fwd_full ? LD_DONE : LD_REQ;
      end
      LD_REQ: begin
        // An accept on the squash cycle still leaves a response in flight
        if (squash)             next_state = dc_req_accept ? LD_DRAIN : LD_IDLE;
        else if (dc_req_accept) next_state = LD_WAIT;
      end
      LD_WAIT: begin
        if (squash)             next_state = dc_resp_valid ? LD_IDLE : LD_DRAIN;
        else if (dc_resp_valid) next_state = LD_DONE;
      end
      LD_DRAIN: begin
        if (dc_resp_valid) next_state = LD_IDLE;
      end
      LD_DONE: begin
        if (capture)                    next_state = LD_QUERY;
        else if (cmpl_accept || squash) next_state = LD_IDLE;
      end
      default: next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt      <= NOP_LOAD_DATA_PACKET;
      fwd_mask <= '0;
      fwd_data <= '0;
      word     <= '0;
    end else begin
      if (capture) begin
        pkt    <= load_data_packet;
        pkt.bm <= load_data_packet.bm & ~b_mm_resolve;
      end else begin
        if (!b_mm_mispred) pkt.bm <= pkt.bm & ~b_mm_resolve;
        if (next_state == LD_IDLE || next_state == LD_DRAIN) pkt.valid <= 1'b0;
      end

      if (state == LD_QUERY && !sq_stall && !squash) begin
        fwd_mask <= sq_fwd_mask;
        fwd_data <= sq_fwd_data;
        if (fwd_full) word <= lane_merge(sq_fwd_mask, sq_fwd_data, '0);
      end

      if (state == LD_WAIT && dc_resp_valid && !squash) begin
        word <= lane_merge(fwd_mask, fwd_data, dc_resp_data);
      end
    end
  end

  always_comb begin
    load_data_free    = (state == LD_IDLE) | ((state == LD_DONE) & cmpl_accept);
    sq_query_addr     = word_addr;
    sq_query_mask     = pkt.byte_mask;
    sq_query_tail     = pkt.sq_tail;
    dc_req_valid      = (state == LD_REQ) & ~squash;
    dc_req_addr       = word_addr;
    cmpl_valid        = (state == LD_DONE) & ~squash;
    cmpl_dest_reg_idx = pkt.dest_reg_idx;
    cmpl_bm           = b_mm_mispred ? pkt.bm : (pkt.bm & ~b_mm_resolve);
  end

  load_align_ext u_align (
    .word      (word),
    .byte_off  (pkt.load_addr[1:0]),
    .load_func (pkt.load_func),
    .result    (cmpl_data)
  );

endmodule

// File: tb/tb_load_data_stage.sv
// Directed bench for load_data_stage with a byte-level result model and a completion scoreboard.
// Latency: n/a. Backpressure: cache accepts immediately, CDB grants immediately unless a test holds it.
module tb_load_data_stage;
  import sys_defs::*;

  logic                 clock;
  logic                 reset;
  LOAD_DATA_PACKET      load_data_packet;
  logic                 load_data_free;
  logic [31:0]          sq_query_addr;
  logic [3:0]           sq_query_mask;
  logic [2:0]           sq_query_tail;
  logic [3:0]           sq_fwd_mask;
  logic [31:0]          sq_fwd_data;
  logic                 sq_stall;
  logic                 dc_req_valid;
  logic [31:0]          dc_req_addr;
  logic                 dc_req_accept;
  logic                 dc_resp_valid;
  logic [31:0]          dc_resp_data;
  logic                 cmpl_valid;
  logic [5:0]           cmpl_dest_reg_idx;
  logic [31:0]          cmpl_data;
  logic [7:0]           cmpl_bm;
  logic                 cmpl_accept;
  logic [7:0]           b_mm_resolve;
  logic                 b_mm_mispred;

  load_data_stage dut (
    .clock(clock), .reset(reset), .load_data_packet(load_data_packet),
    .load_data_free(load_data_free), .sq_query_addr(sq_query_addr),
    .sq_query_mask(sq_query_mask), .sq_query_tail(sq_query_tail),
    .sq_fwd_mask(sq_fwd_mask), .sq_fwd_data(sq_fwd_data), .sq_stall(sq_stall),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_accept(dc_req_accept),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .cmpl_valid(cmpl_valid), .cmpl_dest_reg_idx(cmpl_dest_reg_idx), .cmpl_data(cmpl_data),
    .cmpl_bm(cmpl_bm), .cmpl_accept(cmpl_accept),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic [7:0]  bm;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Byte-level view of the load: pick each lane, take the addressed bytes, then extend
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] func,
                                             input logic [3:0] fmask, input logic [31:0] fdata,
                                             input logic [31:0] resp);
    logic [7:0]  b [4];
    int          off;
    int          nbytes;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) b[i] = fmask[i] ? fdata[8*i +: 8] : resp[8*i +: 8];
    off    = int'(addr[1:0]);
    nbytes = (func[1:0] == 2'd0) ? 1 : (func[1:0] == 2'd1) ? 2 : 4;
    v      = 32'h0;
    for (int k = 0; k < nbytes; k++)
      if (off + k < 4) v = v | (32'(b[off+k]) << (8*k));
    if (!func[2] && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
    return v;
  endfunction

  always @(negedge clock) begin
    if (reset && cmpl_valid && cmpl_accept) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_cmpl: got idx %h data %h, required no completion",
                 cmpl_dest_reg_idx, cmpl_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("sb_idx", 32'(cmpl_dest_reg_idx), 32'(e.idx));
        check("sb_data", cmpl_data, e.data);
        check("sb_bm", 32'(cmpl_bm), 32'(e.bm));
      end
    end
  end

  task automatic drive_pkt(input logic [5:0] idx, input logic [7:0] bm, input logic [31:0] addr,
                           input logic [3:0] bmask, input logic [2:0] func);
    load_data_packet = '{valid: 1'b1, dest_reg_idx: idx, bm: bm, load_addr: addr,
                         byte_mask: bmask, sq_tail: 3'd2, load_func: func};
  endtask

  task automatic do_load(input string name, input logic [5:0] idx, input logic [7:0] bm,
                         input logic [31:0] addr, input logic [3:0] bmask, input logic [2:0] func,
                         input logic [3:0] fmask, input logic [31:0] fdata, input logic [31:0] resp,
                         input logic [7:0] cap_res, input int stall, input int exp_lat,
                         input logic exp_cache, input logic [31:0] exp_data);
    int   lat;
    logic saw_req;
    logic pend;
    exp_t e;
    lat     = -1;
    saw_req = 1'b0;
    pend    = 1'b0;
    e.idx   = idx;
    e.data  = model_load(addr, func, fmask, fdata, resp);
    e.bm    = bm & ~cap_res;
    expq.push_back(e);
    drive_pkt(idx, bm, addr, bmask, func);
    sq_fwd_mask  = fmask;
    sq_fwd_data  = fdata;
    sq_stall     = (stall > 0);
    dc_resp_data = resp;
    b_mm_resolve = cap_res;
    b_mm_mispred = 1'b0;
    tick();
    load_data_packet = NOP_LOAD_DATA_PACKET;
    b_mm_resolve     = 8'h00;
    for (int c = 1; c <= 15; c++) begin
      sq_stall      = (c - 1 < stall);
      dc_resp_valid = pend;
      pend          = 1'b0;
      @(negedge clock);
      if (dc_req_valid) begin
        saw_req = 1'b1;
        pend    = 1'b1;
      end
      if (cmpl_valid) begin
        lat = c - 1;
        check({name, "_data"}, cmpl_data, exp_data);
        break;
      end
      tick();
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_cache_used"}, 32'(saw_req), 32'(exp_cache));
    tick();
    sq_stall      = 1'b0;
    dc_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    load_data_packet = NOP_LOAD_DATA_PACKET;
    sq_fwd_mask      = 4'h0;
    sq_fwd_data      = 32'h0;
    sq_stall         = 1'b0;
    dc_req_accept    = 1'b1;
    dc_resp_valid    = 1'b0;
    dc_resp_data     = 32'h0;
    cmpl_accept      = 1'b1;
    b_mm_resolve     = 8'h00;
    b_mm_mispred     = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check("rst_free", 32'(load_data_free), 32'd1);
    check("rst_cmpl_valid", 32'(cmpl_valid), 32'd0);
    check("rst_dc_req_valid", 32'(dc_req_valid), 32'd0);
    check("rst_cmpl_data", cmpl_data, 32'h0);
    check("rst_cmpl_idx", 32'(cmpl_dest_reg_idx), 32'd0);
    check("rst_cmpl_bm", 32'(cmpl_bm), 32'd0);
    check("rst_sq_query_addr", sq_query_addr, 32'h0);
    reset = 1'b1;
    tick();

    do_load("lw_cache", 6'd1, 8'h01, 32'h1000, 4'hF, 3'b010, 4'h0, 32'h0, 32'hDEADBEEF,
            8'h00, 0, 3, 1'b1, 32'hDEADBEEF);
    do_load("lb_sext", 6'd2, 8'h00, 32'h1003, 4'h8, 3'b000, 4'h0, 32'h0, 32'h80000000,
            8'h00, 0, 3, 1'b1, 32'hFFFFFF80);
    do_load("lbu_zext", 6'd3, 8'h00, 32'h1003, 4'h8, 3'b100, 4'h0, 32'h0, 32'h80000000,
            8'h00, 0, 3, 1'b1, 32'h00000080);
    do_load("lh_fullfwd", 6'd4, 8'h10, 32'h2002, 4'hC, 3'b001, 4'hC, 32'h12340000, 32'h0,
            8'h00, 0, 1, 1'b0, 32'h00001234);
    do_load("lw_partfwd", 6'd5, 8'h0C, 32'h3000, 4'hF, 3'b010, 4'h3, 32'h0000AAAA, 32'h11223344,
            8'h04, 0, 3, 1'b1, 32'h1122AAAA);
    do_load("lh_sext_hi", 6'd6, 8'h00, 32'h2002, 4'hC, 3'b001, 4'h0, 32'h0, 32'h80001234,
            8'h00, 0, 3, 1'b1, 32'hFFFF8000);
    do_load("lbu_fwd_stall", 6'd7, 8'h00, 32'h4001, 4'h2, 3'b100, 4'h2, 32'h0000F000, 32'h0,
            8'h00, 2, 3, 1'b0, 32'h000000F0);

    // Incoming packet killed by a mispredict on its capture cycle
    drive_pkt(6'd8, 8'h08, 32'h1000, 4'hF, 3'b010);
    b_mm_resolve = 8'h08;
    b_mm_mispred = 1'b1;
    tick();
    load_data_packet = NOP_LOAD_DATA_PACKET;
    b_mm_resolve     = 8'h00;
    b_mm_mispred     = 1'b0;
    @(negedge clock);
    check("in_squash_free", 32'(load_data_free), 32'd1);
    tick();
    @(negedge clock);
    check("in_squash_no_req", 32'(dc_req_valid), 32'd0);
    tick();

    // Mispredict while waiting on the cache: drain the response, never complete
    drive_pkt(6'd9, 8'h04, 32'h5000, 4'hF, 3'b010);
    sq_fwd_mask = 4'h0;
    tick();
    load_data_packet = NOP_LOAD_DATA_PACKET;
    tick();
    tick();
    b_mm_resolve = 8'h04;
    b_mm_mispred = 1'b1;
    @(negedge clock);
    check("wait_squash_cmpl", 32'(cmpl_valid), 32'd0);
    check("wait_squash_free", 32'(load_data_free), 32'd0);
    tick();
    b_mm_resolve = 8'h00;
    b_mm_mispred = 1'b0;
    @(negedge clock);
    check("drain_free", 32'(load_data_free), 32'd0);
    check("drain_no_req", 32'(dc_req_valid), 32'd0);
    tick();
    dc_resp_valid = 1'b1;
    dc_resp_data  = 32'h99999999;
    @(negedge clock);
    check("drain_resp_free", 32'(load_data_free), 32'd0);
    tick();
    dc_resp_valid = 1'b0;
    @(negedge clock);
    check("drain_done_free", 32'(load_data_free), 32'd1);
    check("drain_done_cmpl", 32'(cmpl_valid), 32'd0);
    tick();
    tick();

    // Result held in DONE while a correctly-predicted branch resolves
    cmpl_accept = 1'b0;
    drive_pkt(6'd10, 8'h06, 32'h6000, 4'hF, 3'b010);
    sq_fwd_mask = 4'hF;
    sq_fwd_data = 32'hCAFEF00D;
    tick();
    load_data_packet = NOP_LOAD_DATA_PACKET;
    tick();
    @(negedge clock);
    check("done_hold_valid", 32'(cmpl_valid), 32'd1);
    check("done_hold_bm", 32'(cmpl_bm), 32'h06);
    tick();
    b_mm_resolve = 8'h02;
    @(negedge clock);
    check("resolve_bm_same_cycle", 32'(cmpl_bm), 32'h04);
    tick();
    b_mm_resolve = 8'h00;
    @(negedge clock);
    check("resolve_bm_kept", 32'(cmpl_bm), 32'h04);
    check("resolve_still_valid", 32'(cmpl_valid), 32'd1);
    expq.push_back('{idx: 6'd10, data: 32'hCAFEF00D, bm: 8'h04});
    tick();
    cmpl_accept = 1'b1;
    sq_fwd_mask = 4'h0;
    tick();
    tick();

    // Reset asserted while a cache request is outstanding
    dc_req_accept = 1'b0;
    drive_pkt(6'd11, 8'h01, 32'h7000, 4'hF, 3'b010);
    tick();
    load_data_packet = NOP_LOAD_DATA_PACKET;
    tick();
    @(negedge clock);
    check("req_before_reset", 32'(dc_req_valid), 32'd1);
    check("req_addr", dc_req_addr, 32'h7000);
    reset = 1'b0;
    tick();
    @(negedge clock);
    check("midrst_free", 32'(load_data_free), 32'd1);
    check("midrst_req", 32'(dc_req_valid), 32'd0);
    check("midrst_cmpl_data", cmpl_data, 32'h0);
    check("midrst_cmpl_idx", 32'(cmpl_dest_reg_idx), 32'd0);
    reset         = 1'b1;
    dc_req_accept = 1'b1;
    tick();
    dc_resp_valid = 1'b1;
    dc_resp_data  = 32'h55555555;
    @(negedge clock);
    check("stale_resp_ignored", 32'(cmpl_valid), 32'd0);
    tick();
    dc_resp_valid = 1'b0;
    tick();

    do_load("lw_after_reset", 6'd12, 8'h00, 32'h8004, 4'hF, 3'b010, 4'h0, 32'h0, 32'h01020304,
            8'h00, 0, 3, 1'b1, 32'h01020304);
    tick();
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
